// File: rtl/hive_damage_writer_pkg.sv
// Shared definitions for the hive sprite RAM and its write-side clients.
// Holds the hive geometry, the RAM write-select encodings, the pixel value
// that counts as empty, and the state type of the damage writer.
package hive_damage_writer_pkg;

   // Hive sprite geometry and RAM addressing
   localparam int unsigned HIVE_W      = 66;
   localparam int unsigned HIVE_H      = 39;
   localparam int unsigned HIVE_PIXELS = 2574;
   localparam int unsigned HIVE_ADDR_W = 12;
   localparam int unsigned PIX_W       = 8;

   // Signed window coordinates; the range -4..69 needs 8 bits
   localparam int unsigned COORD_W = 8;

   // Default damage window size and its cell counter width (window is 1..8 wide)
   localparam int unsigned DMG_W_DEF = 4;
   localparam int unsigned DMG_H_DEF = 4;
   localparam int unsigned CNT_W     = 3;

   // Background pixel; anything else is solid hive material
   localparam logic [PIX_W-1:0] BLANK = 8'h00;

   // RAM write-select encodings
   localparam logic [1:0] MEM_RD = 2'b00;
   localparam logic [1:0] MEM_WR = 2'b01;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD    = 3'd1,
      CHECK = 3'd2,
      WR    = 3'd3,
      NEXT  = 3'd4,
      DONE  = 3'd5
   } dmg_state_e;

endpackage : hive_damage_writer_pkg

// File: rtl/hive_pixel_addr.sv
// Maps a signed hive pixel coordinate to a linear RAM address and flags
// whether the coordinate lies inside the hive sprite.
//   px_i        : signed column
//   py_i        : signed row
//   mem_addr_o  : py*HIVE_W + px (meaningful only when in_bounds_o = 1)
//   in_bounds_o : 1 when 0 <= px < HIVE_W and 0 <= py < HIVE_H
module hive_pixel_addr
   import hive_damage_writer_pkg::*;
(
   input  logic signed [COORD_W-1:0]     px_i,
   input  logic signed [COORD_W-1:0]     py_i,
   output logic        [HIVE_ADDR_W-1:0] mem_addr_o,
   output logic                          in_bounds_o
);

   localparam logic [COORD_W-1:0] W_LIM = COORD_W'(HIVE_W);
   localparam logic [COORD_W-1:0] H_LIM = COORD_W'(HIVE_H);

   logic [HIVE_ADDR_W-1:0] col_w;
   logic [HIVE_ADDR_W-1:0] row_w;

   // Only the low bits matter once the coordinate is known to be in range
   assign col_w = HIVE_ADDR_W'(px_i[6:0]);
   assign row_w = HIVE_ADDR_W'(py_i[5:0]);

   // row*66 as (row<<6)+(row<<1); max 38*66+65 = 2573 fits in 12 bits
   assign mem_addr_o = (row_w << 6) + (row_w << 1) + col_w;

   // Sign bit rules out negatives, so the unsigned compare covers the upper bound
   assign in_bounds_o = !px_i[COORD_W-1] && ($unsigned(px_i) < W_LIM) &&
                        !py_i[COORD_W-1] && ($unsigned(py_i) < H_LIM);

endmodule : hive_pixel_addr

// File: rtl/hive_damage_writer.sv
// Bullet-hit eroder for the hive sprite RAM. On a hit request it walks a
// DMG_W x DMG_H window centred on the hit point, reads every in-bounds
// pixel and writes BLANK over each solid one, then reports whether any
// solid pixel was erased. The RAM port is shared with the renderer; this
// block only acts on cycles where mem_en is high.
//   clk_pix   : pixel clock
//   reset     : synchronous active-high reset
//   mem_en    : this block owns the RAM port this cycle
//   hit_valid : hit request strobe (accepted in IDLE only)
//   hit_x/y   : hit column / row
//   busy      : operation in progress
//   done      : one-cycle completion pulse
//   hit_solid : at least one solid pixel erased, valid with done
//   mem_addr  : RAM address
//   mem_write : RAM write select (00 read, 01 write)
//   mem_data  : RAM write data (always BLANK)
//   mem_dout  : RAM registered read data
module hive_damage_writer
   import hive_damage_writer_pkg::*;
#(
   parameter int unsigned DMG_W = DMG_W_DEF,
   parameter int unsigned DMG_H = DMG_H_DEF
) (
   input  logic                   clk_pix,
   input  logic                   reset,
   input  logic                   mem_en,
   input  logic                   hit_valid,
   input  logic [6:0]             hit_x,
   input  logic [5:0]             hit_y,
   output logic                   busy,
   output logic                   done,
   output logic                   hit_solid,
   output logic [HIVE_ADDR_W-1:0] mem_addr,
   output logic [1:0]             mem_write,
   output logic [PIX_W-1:0]       mem_data,
   input  logic [PIX_W-1:0]       mem_dout
);

   localparam logic [CNT_W-1:0]   COL_LAST = CNT_W'(DMG_W - 1);
   localparam logic [CNT_W-1:0]   ROW_LAST = CNT_W'(DMG_H - 1);
   localparam logic [COORD_W-1:0] X_HALF   = COORD_W'(DMG_W / 2);
   localparam logic [COORD_W-1:0] Y_HALF   = COORD_W'(DMG_H / 2);

   dmg_state_e                   state_q, state_d;
   logic signed [COORD_W-1:0]    ox_q, ox_d;
   logic signed [COORD_W-1:0]    oy_q, oy_d;
   logic [CNT_W-1:0]             col_q, col_d;
   logic [CNT_W-1:0]             row_q, row_d;
   logic                         solid_q, solid_d;
   logic                         hit_solid_q, hit_solid_d;
   logic                         inb_q;
   logic                         busy_q;
   logic                         done_q;
   logic [HIVE_ADDR_W-1:0]       mem_addr_q;
   logic [1:0]                   mem_write_q;

   logic signed [COORD_W-1:0]    px_n;
   logic signed [COORD_W-1:0]    py_n;
   logic [HIVE_ADDR_W-1:0]       addr_n;
   logic                         inb_n;

   // Address of the cell the FSM will be working on next cycle
   hive_pixel_addr u_pixel_addr (
      .px_i        (px_n),
      .py_i        (py_n),
      .mem_addr_o  (addr_n),
      .in_bounds_o (inb_n)
   );

   // Next-state, window walk and look-ahead cell coordinates
   always_comb begin
      state_d     = state_q;
      ox_d        = ox_q;
      oy_d        = oy_q;
      col_d       = col_q;
      row_d       = row_q;
      solid_d     = solid_q;
      hit_solid_d = hit_solid_q;

      if (mem_en) begin
         unique case (state_q)
            IDLE: begin
               if (hit_valid) begin
                  ox_d        = $signed(COORD_W'(hit_x)) - $signed(X_HALF);
                  oy_d        = $signed(COORD_W'(hit_y)) - $signed(Y_HALF);
                  col_d       = '0;
                  row_d       = '0;
                  solid_d     = 1'b0;
                  hit_solid_d = 1'b0;
                  state_d     = RD;
               end
            end
            RD:    state_d = inb_q ? CHECK : NEXT;
            CHECK: begin
               if (mem_dout != BLANK) begin
                  solid_d = 1'b1;
                  state_d = WR;
               end else begin
                  state_d = NEXT;
               end
            end
            WR:    state_d = NEXT;
            NEXT: begin
               if (col_q == COL_LAST) begin
                  if (row_q == ROW_LAST) begin
                     state_d = DONE;
                  end else begin
                     col_d   = '0;
                     row_d   = row_q + CNT_W'(1);
                     state_d = RD;
                  end
               end else begin
                  col_d   = col_q + CNT_W'(1);
                  state_d = RD;
               end
            end
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end else if (state_q == CHECK || state_q == WR) begin
         // Renderer may have reused the read port; restart this cell from its read
         state_d = RD;
      end

      if (state_d == DONE) begin
         hit_solid_d = solid_q;
      end

      px_n = ox_d + $signed(COORD_W'(col_d));
      py_n = oy_d + $signed(COORD_W'(row_d));
   end

   // State and output registers; outputs are decoded from the next state so
   // they line up with the state they describe
   always_ff @(posedge clk_pix) begin
      if (reset) begin
         state_q     <= IDLE;
         ox_q        <= '0;
         oy_q        <= '0;
         col_q       <= '0;
         row_q       <= '0;
         solid_q     <= 1'b0;
         hit_solid_q <= 1'b0;
         inb_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         mem_addr_q  <= '0;
         mem_write_q <= MEM_RD;
      end else begin
         state_q     <= state_d;
         ox_q        <= ox_d;
         oy_q        <= oy_d;
         col_q       <= col_d;
         row_q       <= row_d;
         solid_q     <= solid_d;
         hit_solid_q <= hit_solid_d;
         inb_q       <= inb_n;
         busy_q      <= (state_d != IDLE);
         done_q      <= (state_d == DONE);
         mem_write_q <= (state_d == WR) ? MEM_WR : MEM_RD;
         // Address only moves for in-bounds cells; skipped cells leave the port untouched
         if (state_d == RD && inb_n) begin
            mem_addr_q <= addr_n;
         end
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign hit_solid = hit_solid_q;
   assign mem_addr  = mem_addr_q;
   // Port ownership gate: a write can never reach the RAM while the renderer owns it
   assign mem_write = mem_en ? mem_write_q : MEM_RD;
   assign mem_data  = BLANK;

endmodule : hive_damage_writer

// File: tb/tb_hive_damage_writer.sv
module tb_hive_damage_writer;

   logic        clk_pix   = 1'b0;
   logic        reset     = 1'b1;
   logic        mem_en    = 1'b1;
   logic        hit_valid = 1'b0;
   logic [6:0]  hit_x     = 7'd0;
   logic [5:0]  hit_y     = 6'd0;
   logic        busy;
   logic        done;
   logic        hit_solid;
   logic [11:0] mem_addr;
   logic [1:0]  mem_write;
   logic [7:0]  mem_data;
   logic [7:0]  mem_dout  = 8'h00;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk_pix = ~clk_pix;

   hive_damage_writer dut (
      .clk_pix   (clk_pix),
      .reset     (reset),
      .mem_en    (mem_en),
      .hit_valid (hit_valid),
      .hit_x     (hit_x),
      .hit_y     (hit_y),
      .busy      (busy),
      .done      (done),
      .hit_solid (hit_solid),
      .mem_addr  (mem_addr),
      .mem_write (mem_write),
      .mem_data  (mem_data),
      .mem_dout  (mem_dout)
   );

   // RAM model: registered read; renderer reads a blank address when it owns the port
   logic [7:0]  ram [0:4095];
   logic        fill_req = 1'b0;
   logic [7:0]  fill_val = 8'h00;
   logic [11:0] ram_a;
   assign ram_a = mem_en ? mem_addr : 12'd3000;

   always @(posedge clk_pix) begin
      if (fill_req) begin
         for (int i = 0; i < 4096; i++) ram[i] <= (i < 2574) ? fill_val : 8'h00;
      end else if (mem_en && mem_write == 2'b01) begin
         ram[mem_addr] <= mem_data;
      end
      mem_dout <= ram[ram_a];
   end

   // Access log: a read is a new address presented while owning the port
   logic log_en    = 1'b0;
   int   last_addr = -1;
   int   rd_q[$];
   int   wr_q[$];
   int   bad_data  = 0;
   int   max_addr  = 0;

   always @(posedge clk_pix) begin
      if (!log_en) begin
         last_addr = -1;
      end else if (mem_en === 1'b1) begin
         if (mem_write === 2'b01) begin
            wr_q.push_back(int'(mem_addr));
            if (mem_data !== 8'h00) bad_data++;
         end else if (busy === 1'b1 && int'(mem_addr) != last_addr) begin
            rd_q.push_back(int'(mem_addr));
            last_addr = int'(mem_addr);
         end
         if (busy === 1'b1 && int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk_pix);
      #1;
   endtask

   task automatic fill(input logic [7:0] v);
      fill_val = v;
      fill_req = 1'b1;
      tick();
      fill_req = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic clear_log();
      rd_q.delete();
      wr_q.delete();
      bad_data = 0;
      max_addr = 0;
   endtask

   // Expected access order for a window whose in-bounds cells are all visited
   task automatic build_exp(input int ox, input int oy, output int q[$]);
      q.delete();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (ox + c >= 0 && ox + c < 66 && oy + r >= 0 && oy + r < 39)
               q.push_back((oy + r) * 66 + ox + c);
   endtask

   task automatic run_hit(input logic [6:0] x, input logic [5:0] y,
                          output int cyc, output int dn, output logic sol);
      clear_log();
      log_en    = 1'b1;
      hit_x     = x;
      hit_y     = y;
      hit_valid = 1'b1;
      tick();
      hit_valid = 1'b0;
      cyc = 0;
      dn  = 0;
      sol = 1'b0;
      while (busy === 1'b1 && cyc < 400) begin
         cyc++;
         if (done === 1'b1) begin
            dn++;
            sol = hit_solid;
         end
         tick();
      end
      log_en = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
      n_cmp++; if (hit_solid !== 1'b0) begin n_bad++; $display("FAIL reset_hit_solid: got %b want 0", hit_solid); end
      n_cmp++; if (mem_addr !== 12'd0) begin n_bad++; $display("FAIL reset_mem_addr: got %0d want 0", mem_addr); end
      n_cmp++; if (mem_write !== 2'b00) begin n_bad++; $display("FAIL reset_mem_write: got %b want 00", mem_write); end
      n_cmp++; if (mem_data !== 8'h00) begin n_bad++; $display("FAIL reset_mem_data: got %h want 00", mem_data); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_interior_blank();
      int cyc, dn; logic sol; int exp[$];
      fill(8'h00);
      do_reset();
      run_hit(7'd10, 6'd10, cyc, dn, sol);
      build_exp(8, 8, exp);
      n_cmp++; if (exp[0] != 536 || exp[15] != 737) begin n_bad++; $display("FAIL blank_model: first %0d last %0d want 536 737", exp[0], exp[15]); end
      n_cmp++; if (cyc != 49) begin n_bad++; $display("FAIL blank_busy_cycles: got %0d want 49", cyc); end
      n_cmp++; if (dn != 1) begin n_bad++; $display("FAIL blank_done_pulses: got %0d want 1", dn); end
      n_cmp++; if (sol !== 1'b0) begin n_bad++; $display("FAIL blank_hit_solid: got %b want 0", sol); end
      n_cmp++; if (wr_q.size() != 0) begin n_bad++; $display("FAIL blank_writes: got %0d want 0", wr_q.size()); end
      n_cmp++; if (rd_q.size() != 16) begin n_bad++; $display("FAIL blank_reads: got %0d want 16", rd_q.size()); end
      for (int i = 0; i < 16; i++) begin
         int got;
         got = (i < rd_q.size()) ? rd_q[i] : -1;
         n_cmp++; if (got != exp[i]) begin n_bad++; $display("FAIL blank_rd_addr[%0d]: got %0d want %0d", i, got, exp[i]); end
      end
   endtask

   task automatic test_interior_solid();
      int cyc, dn; logic sol; int exp[$];
      fill(8'h3C);
      do_reset();
      run_hit(7'd10, 6'd10, cyc, dn, sol);
      build_exp(8, 8, exp);
      n_cmp++; if (cyc != 65) begin n_bad++; $display("FAIL solid_busy_cycles: got %0d want 65", cyc); end
      n_cmp++; if (dn != 1) begin n_bad++; $display("FAIL solid_done_pulses: got %0d want 1", dn); end
      n_cmp++; if (sol !== 1'b1) begin n_bad++; $display("FAIL solid_hit_solid: got %b want 1", sol); end
      n_cmp++; if (wr_q.size() != 16) begin n_bad++; $display("FAIL solid_writes: got %0d want 16", wr_q.size()); end
      n_cmp++; if (bad_data != 0) begin n_bad++; $display("FAIL solid_wr_data: got %0d non-blank writes want 0", bad_data); end
      for (int i = 0; i < 16; i++) begin
         int gw, gr;
         gw = (i < wr_q.size()) ? wr_q[i] : -1;
         gr = (i < rd_q.size()) ? rd_q[i] : -1;
         n_cmp++; if (gw != exp[i] || gr != exp[i]) begin n_bad++; $display("FAIL solid_rd_wr[%0d]: rd %0d wr %0d want %0d", i, gr, gw, exp[i]); end
      end
      for (int a = 536; a <= 539; a++) begin
         n_cmp++; if (ram[a] !== 8'h00) begin n_bad++; $display("FAIL solid_ram[%0d]: got %h want 00", a, ram[a]); end
      end
      n_cmp++; if (ram[540] !== 8'h3C) begin n_bad++; $display("FAIL solid_ram_neighbour: got %h want 3c", ram[540]); end
      tick(); tick();
      n_cmp++; if (hit_solid !== 1'b1) begin n_bad++; $display("FAIL solid_hold: got %b want 1", hit_solid); end
   endtask

   task automatic test_corner_clip();
      int cyc, dn; logic sol;
      int exp[4] = '{0, 1, 66, 67};
      fill(8'h3C);
      do_reset();
      run_hit(7'd0, 6'd0, cyc, dn, sol);
      // 4 solid cells x4 + 12 skipped cells x2 + DONE
      n_cmp++; if (cyc != 41) begin n_bad++; $display("FAIL corner_busy_cycles: got %0d want 41", cyc); end
      n_cmp++; if (rd_q.size() != 4) begin n_bad++; $display("FAIL corner_reads: got %0d want 4", rd_q.size()); end
      n_cmp++; if (wr_q.size() != 4) begin n_bad++; $display("FAIL corner_writes: got %0d want 4", wr_q.size()); end
      for (int i = 0; i < 4; i++) begin
         int gw, gr;
         gw = (i < wr_q.size()) ? wr_q[i] : -1;
         gr = (i < rd_q.size()) ? rd_q[i] : -1;
         n_cmp++; if (gw != exp[i] || gr != exp[i]) begin n_bad++; $display("FAIL corner_addr[%0d]: rd %0d wr %0d want %0d", i, gr, gw, exp[i]); end
      end
      n_cmp++; if (ram[2] !== 8'h3C || ram[132] !== 8'h3C) begin n_bad++; $display("FAIL corner_untouched: got %h %h want 3c 3c", ram[2], ram[132]); end
      n_cmp++; if (sol !== 1'b1) begin n_bad++; $display("FAIL corner_hit_solid: got %b want 1", sol); end
   endtask

   task automatic test_far_corner();
      int cyc, dn; logic sol;
      int exp[9] = '{2439, 2440, 2441, 2505, 2506, 2507, 2571, 2572, 2573};
      fill(8'h00);
      do_reset();
      run_hit(7'd65, 6'd38, cyc, dn, sol);
      // 9 empty cells x3 + 7 skipped cells x2 + DONE
      n_cmp++; if (cyc != 42) begin n_bad++; $display("FAIL far_busy_cycles: got %0d want 42", cyc); end
      n_cmp++; if (rd_q.size() != 9) begin n_bad++; $display("FAIL far_reads: got %0d want 9", rd_q.size()); end
      for (int i = 0; i < 9; i++) begin
         int gr;
         gr = (i < rd_q.size()) ? rd_q[i] : -1;
         n_cmp++; if (gr != exp[i]) begin n_bad++; $display("FAIL far_rd_addr[%0d]: got %0d want %0d", i, gr, exp[i]); end
      end
      n_cmp++; if (max_addr != 2573) begin n_bad++; $display("FAIL far_max_addr: got %0d want 2573", max_addr); end
      n_cmp++; if (wr_q.size() != 0 || sol !== 1'b0) begin n_bad++; $display("FAIL far_no_write: writes %0d solid %b want 0 0", wr_q.size(), sol); end
   endtask

   task automatic test_mem_en_gap();
      int cyc, dn; logic sol; int exp[$];
      fill(8'h3C);
      do_reset();
      build_exp(8, 8, exp);
      clear_log();
      log_en    = 1'b1;
      hit_x     = 7'd10;
      hit_y     = 6'd10;
      hit_valid = 1'b1;
      tick();
      hit_valid = 1'b0;
      tick();                       // now in CHECK on the first (solid) cell
      mem_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_cmp++; if (mem_write !== 2'b00) begin n_bad++; $display("FAIL gap_mem_write[%0d]: got %b want 00", i, mem_write); end
      end
      mem_en = 1'b1;
      cyc = 0; dn = 0; sol = 1'b0;
      while (busy === 1'b1 && cyc < 400) begin
         cyc++;
         if (done === 1'b1) begin dn++; sol = hit_solid; end
         tick();
      end
      log_en = 1'b0;
      n_cmp++; if (dn != 1 || sol !== 1'b1) begin n_bad++; $display("FAIL gap_done: pulses %0d solid %b want 1 1", dn, sol); end
      n_cmp++; if (wr_q.size() != 16) begin n_bad++; $display("FAIL gap_writes: got %0d want 16", wr_q.size()); end
      for (int i = 0; i < 16; i++) begin
         int gw;
         gw = (i < wr_q.size()) ? wr_q[i] : -1;
         n_cmp++; if (gw != exp[i]) begin n_bad++; $display("FAIL gap_wr_addr[%0d]: got %0d want %0d", i, gw, exp[i]); end
         n_cmp++; if (ram[exp[i]] !== 8'h00) begin n_bad++; $display("FAIL gap_ram[%0d]: got %h want 00", exp[i], ram[exp[i]]); end
      end
      n_cmp++; if (ram[540] !== 8'h3C || ram[3000] !== 8'h00) begin n_bad++; $display("FAIL gap_ram_other: got %h %h want 3c 00", ram[540], ram[3000]); end
   endtask

   task automatic test_reset_mid();
      int cyc, dn; logic sol;
      fill(8'h3C);
      do_reset();
      clear_log();
      log_en    = 1'b1;
      hit_x     = 7'd10;
      hit_y     = 6'd10;
      hit_valid = 1'b1;
      tick();
      hit_valid = 1'b0;
      // RD, CHECK, WR, NEXT of cell 0, then RD, CHECK of cell 1
      for (int i = 0; i < 5; i++) tick();
      reset = 1'b1;
      tick();
      n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || hit_solid !== 1'b0) begin n_bad++; $display("FAIL midreset_flags: busy %b done %b solid %b want 0 0 0", busy, done, hit_solid); end
      n_cmp++; if (mem_addr !== 12'd0 || mem_write !== 2'b00 || mem_data !== 8'h00) begin n_bad++; $display("FAIL midreset_port: addr %0d wr %b data %h want 0 00 00", mem_addr, mem_write, mem_data); end
      reset = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      log_en = 1'b0;
      n_cmp++; if (wr_q.size() != 1) begin n_bad++; $display("FAIL midreset_writes: got %0d want 1", wr_q.size()); end
      n_cmp++; if (ram[536] !== 8'h00 || ram[537] !== 8'h3C) begin n_bad++; $display("FAIL midreset_ram: got %h %h want 00 3c", ram[536], ram[537]); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midreset_idle: busy %b want 0", busy); end
      // A fresh hit after the abort runs to completion
      run_hit(7'd30, 6'd20, cyc, dn, sol);
      n_cmp++; if (cyc != 65 || dn != 1 || sol !== 1'b1) begin n_bad++; $display("FAIL retrigger: cycles %0d pulses %0d solid %b want 65 1 1", cyc, dn, sol); end
      n_cmp++; if (wr_q.size() != 16) begin n_bad++; $display("FAIL retrigger_writes: got %0d want 16", wr_q.size()); end
   endtask

   task automatic test_ignore_busy();
      int cyc, dn; int exp[$];
      fill(8'h00);
      do_reset();
      build_exp(8, 8, exp);
      clear_log();
      log_en    = 1'b1;
      hit_x     = 7'd10;
      hit_y     = 6'd10;
      hit_valid = 1'b1;
      tick();
      hit_valid = 1'b0;
      cyc = 0; dn = 0;
      while (busy === 1'b1 && cyc < 400) begin
         cyc++;
         if (done === 1'b1) dn++;
         if (cyc == 5 || cyc == 49) begin
            hit_x = 7'd40; hit_y = 6'd20; hit_valid = 1'b1;
         end else begin
            hit_valid = 1'b0;
         end
         tick();
      end
      hit_valid = 1'b0;
      log_en = 1'b0;
      tick();
      n_cmp++; if (cyc != 49 || dn != 1) begin n_bad++; $display("FAIL ignore_cycles: cycles %0d pulses %0d want 49 1", cyc, dn); end
      n_cmp++; if (rd_q.size() != 16) begin n_bad++; $display("FAIL ignore_reads: got %0d want 16", rd_q.size()); end
      n_cmp++; if (rd_q.size() == 16 && rd_q[15] != exp[15]) begin n_bad++; $display("FAIL ignore_last_addr: got %0d want %0d", rd_q[15], exp[15]); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ignore_idle: busy %b want 0", busy); end
   endtask

   initial begin
      fill(8'h00);
      test_reset();
      test_interior_blank();
      test_interior_solid();
      test_corner_clip();
      test_far_corner();
      test_mem_en_gap();
      test_reset_mid();
      test_ignore_busy();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_hive_damage_writer

// File: doc/hive_damage_writer.md
Name: hive_damage_writer

Overview:
Write-side client of a hive sprite RAM (66 x 39 pixels, 8-bit, 1-cycle registered read). On a bullet-hit request, it walks a rectangular damage window around the hit point. For each in-bounds pixel it reads the pixel; if the pixel is solid it writes BLANK back, eroding the hive. It reports whether any solid pixel was hit so the bullet logic can stop the bullet. It sits between the collision logic and the hive RAM's address/write/data port, which it shares with the pixel renderer under an enable gate.

Parameters:
HIVE_W, 66, hive width in pixels
HIVE_H, 39, hive height in pixels
DMG_W, 4, damage window width (1..8)
DMG_H, 4, damage window height (1..8)
BLANK, 8'h00, background pixel value; pixel == BLANK is empty

Ports:
clk_pix  in  1  pixel clock; the only clock
reset  in  1  synchronous, active-high reset
mem_en  in  1  1 = this block owns the RAM port this cycle
hit_valid  in  1  hit request strobe
hit_x  in  7  hit column, 0..65
hit_y  in  6  hit row, 0..38
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse
hit_solid  out  1  at least one solid pixel was erased; valid with done
mem_addr  out  12  RAM address = row*HIVE_W + col
mem_write  out  2  2'b01 write, 2'b00 read (RAM write-select encoding)
mem_data  out  8  write data, always BLANK during writes
mem_dout  in  8  RAM registered read data

Behaviour:
- Reset: all outputs go to 0 on the next edge (busy=0, done=0, hit_solid=0, mem_addr=0, mem_write=2'b00, mem_data=8'h00), state=IDLE.
- Reset mid-operation aborts immediately. No further write is issued after the reset edge, and no done pulse is generated.
- States are IDLE, RD, CHECK, WR, NEXT, DONE.
- IDLE: on hit_valid=1, latch the window origin ox = hit_x - DMG_W/2 and oy = hit_y - DMG_H/2. Both are 8-bit signed. Clear the solid flag, set col=row=0, and go to RD. hit_valid is ignored in every state except IDLE.
- busy=1 in every state except IDLE.
- RD: compute px=ox+col and py=oy+row as signed values.
  - Out of bounds (px<0, px>=HIVE_W, py<0 or py>=HIVE_H): no RAM access; go to NEXT.
  - In bounds: drive mem_addr=py*HIVE_W+px and mem_write=00; go to CHECK.
- CHECK: mem_dout is valid this cycle; mem_addr is held.
  - mem_dout != BLANK: set the solid flag; go to WR.
  - Otherwise: go to NEXT.
- WR: mem_write=01, mem_data=BLANK, same mem_addr, for exactly one cycle; go to NEXT.
- NEXT: mem_write=00; advance col, and wrap col to 0 with row+1 at DMG_W-1. After the last cell (row=DMG_H-1, col=DMG_W-1), go to DONE; otherwise go to RD.
- DONE: done=1 and busy=1 for one cycle; hit_solid is set from the flag. Then go to IDLE.
- hit_solid holds its value until the next accepted request clears it.
- mem_en=0:
  - The FSM holds its state and mem_write is forced to 00.
  - If mem_en is low in CHECK or WR, resume at RD for the same cell. The RAM data may have been overwritten by the renderer's reads, so it must be re-read; no write is skipped or duplicated.
- Cycle cost with mem_en=1:
  - out-of-bounds cell: 2 cycles (RD, NEXT)
  - empty cell: 3 cycles (RD, CHECK, NEXT)
  - solid cell: 4 cycles (RD, CHECK, WR, NEXT)
  - plus 1 cycle for DONE.
- Address arithmetic: row*66 is done as shift-add, (row<<6)+(row<<1). Maximum address is 2573, which fits in 12 bits.
- A cell is never written without a preceding read of that cell in the same ownership window.

Decomposition:
- Shared package: HIVE_W, HIVE_H, HIVE_PIXELS=2574, HIVE_ADDR_W=12, BLANK, the RAM write-select encodings (MEM_RD=2'b00, MEM_WR=2'b01), and the state enum.
- One natural sub-module: hive_pixel_addr. It is combinational: signed px,py in; mem_addr and in_bounds out. It is reused by the renderer and future hive writers.

Test Plan:
- Interior hit: hit (10,10), RAM all BLANK -> reads of addresses 536..539, 602..605, 668..671, 734..737 (16 reads, 0 writes). busy lasts 16*3+1=49 cycles; done pulses once; hit_solid=0.
- Interior hit, all solid (RAM filled 8'h3C): hit (10,10) -> 16 writes of 8'h00, each directly after a read of the same address. busy lasts 16*4+1=65 cycles; hit_solid=1; RAM at 536..539 reads back 00.
- Corner clip: hit (0,0), window origin (-2,-2) -> only addresses 0, 1, 66, 67 accessed; 12 cells skipped with no RAM activity.
- Far-corner clip: hit (65,38) -> 9 cells accessed, rows 36..38 x cols 63..65; the last address is 2573, and no address above 2573 ever appears.
- mem_en gap: drop mem_en for 5 cycles while in CHECK on a solid cell -> mem_write=00 throughout the gap. On resume the same address is re-read, then written once, and the final RAM contents match the no-gap run.
- Reset and re-trigger: assert reset in the middle of a solid-hit run -> no write after the reset edge, all outputs 0. A hit_valid pulse while busy is ignored, and a new hit after reset completes normally.
